// File: rtl/noc_flit_input_unit.sv
// Router input unit: framing-checked flit FIFO with XY route decode per packet.
// Head-of-FIFO flits are presented to the switch with a route held for the whole packet.
module noc_flit_input_unit #(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned X_W     = 4,
    parameter int unsigned Y_W     = 4,
    parameter int unsigned DST_LSB = 32,
    parameter int unsigned MY_X    = 0,
    parameter int unsigned MY_Y    = 0
) (
    input  logic              noc_clk,
    input  logic              noc_rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_flit,
    input  logic              in_is_header,
    input  logic              in_is_tail,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_flit,
    output logic              out_is_header,
    output logic              out_is_tail,
    output logic [2:0]        out_port,
    output logic              framing_err,
    output logic [15:0]       pkt_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);
    localparam logic [X_W-1:0] MY_X_V = X_W'(MY_X);
    localparam logic [Y_W-1:0] MY_Y_V = Y_W'(MY_Y);

    localparam logic [2:0] PORT_LOCAL = 3'd0;
    localparam logic [2:0] PORT_EAST  = 3'd1;
    localparam logic [2:0] PORT_WEST  = 3'd2;
    localparam logic [2:0] PORT_NORTH = 3'd3;
    localparam logic [2:0] PORT_SOUTH = 3'd4;

    typedef enum logic {StIdle, StActive} rd_state_e;

    logic [DATA_W+1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              r_wr_in_pkt;
    logic              r_framing_err;
    logic [2:0]        r_out_port;
    logic [15:0]       r_pkt_cnt;
    rd_state_e         r_state;

    rd_state_e         w_state_d;
    logic              w_accept;
    logic              w_push;
    logic              w_drop;
    logic              w_pop;
    logic              w_nonempty;
    logic              w_wr_in_pkt_d;
    logic              w_load_route;
    logic [DATA_W+1:0] w_head;
    logic [X_W-1:0]    w_dx;
    logic [Y_W-1:0]    w_dy;
    logic [2:0]        w_route;

    assign in_ready   = (r_count != CNT_FULL);
    assign w_nonempty = (r_count != '0);
    assign w_accept   = in_valid & in_ready;
    // Only a header outside a packet or a non-header inside a packet is stored.
    assign w_push     = w_accept & ((!r_wr_in_pkt & in_is_header) | (r_wr_in_pkt & !in_is_header));
    assign w_drop     = w_accept & !w_push;

    always_comb begin
        w_wr_in_pkt_d = r_wr_in_pkt;
        if (w_push) begin
            if (in_is_header) begin
                w_wr_in_pkt_d = !in_is_tail;
            end else if (in_is_tail) begin
                w_wr_in_pkt_d = 1'b0;
            end
        end
    end

    assign w_head        = r_mem[r_rd_ptr];
    assign out_flit      = w_nonempty ? w_head[DATA_W-1:0] : '0;
    assign out_is_tail   = w_nonempty & w_head[DATA_W];
    assign out_is_header = w_nonempty & w_head[DATA_W+1];

    assign w_dy = w_head[DST_LSB +: Y_W];
    assign w_dx = w_head[DST_LSB + Y_W +: X_W];

    always_comb begin
        w_route = PORT_LOCAL;
        if (w_dx > MY_X_V) begin
            w_route = PORT_EAST;
        end else if (w_dx < MY_X_V) begin
            w_route = PORT_WEST;
        end else if (w_dy > MY_Y_V) begin
            w_route = PORT_NORTH;
        end else if (w_dy < MY_Y_V) begin
            w_route = PORT_SOUTH;
        end
    end

    always_comb begin
        w_state_d    = r_state;
        out_valid    = 1'b0;
        w_pop        = 1'b0;
        w_load_route = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_nonempty && out_is_header) begin
                    w_load_route = 1'b1;
                    w_state_d    = StActive;
                end
            end
            StActive: begin
                out_valid = w_nonempty;
                w_pop     = w_nonempty & out_ready;
                if (w_pop && out_is_tail) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Storage is not reset; empty entries are masked on the outputs.
    always_ff @(posedge noc_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_is_header, in_is_tail, in_flit};
        end
    end

    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_wr_in_pkt   <= 1'b0;
            r_framing_err <= 1'b0;
            r_out_port    <= PORT_LOCAL;
            r_pkt_cnt     <= '0;
            r_state       <= StIdle;
        end else begin
            r_wr_in_pkt   <= w_wr_in_pkt_d;
            r_framing_err <= w_drop;
            r_state       <= w_state_d;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_load_route) begin
                r_out_port <= w_route;
            end
            if (w_pop && out_is_tail) begin
                r_pkt_cnt <= r_pkt_cnt + 16'd1;
            end
        end
    end

    assign out_port    = r_out_port;
    assign framing_err = r_framing_err;
    assign pkt_cnt     = r_pkt_cnt;

endmodule

// File: tb/tb_noc_flit_input_unit.sv
// Scoreboard bench for noc_flit_input_unit: stimulus queues expected flits,
// a negedge monitor pops and compares every flit the switch side accepts.
module tb_noc_flit_input_unit;

    localparam int unsigned DATA_W  = 64;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned X_W     = 4;
    localparam int unsigned Y_W     = 4;
    localparam int unsigned DST_LSB = 32;

    logic              noc_clk = 1'b0;
    logic              noc_rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_flit = '0;
    logic              in_is_header = 1'b0;
    logic              in_is_tail = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_flit;
    logic              out_is_header;
    logic              out_is_tail;
    logic [2:0]        out_port;
    logic              framing_err;
    logic [15:0]       pkt_cnt;

    noc_flit_input_unit #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .X_W    (X_W),
        .Y_W    (Y_W),
        .DST_LSB(DST_LSB),
        .MY_X   (1),
        .MY_Y   (1)
    ) dut (
        .noc_clk      (noc_clk),
        .noc_rst_n    (noc_rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_flit      (in_flit),
        .in_is_header (in_is_header),
        .in_is_tail   (in_is_tail),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_flit     (out_flit),
        .out_is_header(out_is_header),
        .out_is_tail  (out_is_tail),
        .out_port     (out_port),
        .framing_err  (framing_err),
        .pkt_cnt      (pkt_cnt)
    );

    always #5 noc_clk = ~noc_clk;

    typedef struct packed {
        logic [DATA_W-1:0] flit;
        logic              hdr;
        logic              tail;
        logic [2:0]        port;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_exp;
    time  pop_t[$];
    time  last_acc;
    time  t_pop;
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] hdr_flit(input logic [3:0] dx, input logic [3:0] dy,
                                                   input logic [7:0] tag);
        logic [DATA_W-1:0] f;
        f = {56'hAB00_0000_0000_00, tag};
        f[DST_LSB + Y_W +: X_W] = dx;
        f[DST_LSB +: Y_W] = dy;
        return f;
    endfunction

    function automatic logic [DATA_W-1:0] dat_flit(input logic [7:0] tag);
        return {56'hD0D0_0000_5555_00, tag};
    endfunction

    // Drive one flit; if it is expected at the output, queue it first.
    task automatic send(input logic [DATA_W-1:0] f, input logic h, input logic t,
                        input logic expect_out, input logic [2:0] port);
        int cyc;
        exp_t e;
        if (expect_out) begin
            e.flit = f;
            e.hdr  = h;
            e.tail = t;
            e.port = port;
            exp_q.push_back(e);
        end
        in_valid     = 1'b1;
        in_flit      = f;
        in_is_header = h;
        in_is_tail   = t;
        cyc = 0;
        forever begin
            @(negedge noc_clk);
            if (in_ready) break;
            cyc++;
            if (cyc > 50) break;
        end
        if (cyc > 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready=0 for 50 cycles expected 1");
        end
        @(posedge noc_clk);
        last_acc = $time;
        #1;
        in_valid     = 1'b0;
        in_is_header = 1'b0;
        in_is_tail   = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge noc_clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d flits pending expected 0", exp_q.size());
        end
        @(posedge noc_clk);
        #1;
    endtask

    always @(negedge noc_clk) begin
        if (out_valid && out_ready) begin
            n_checks++;
            pop_t.push_back($time);
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_flit: got %h hdr=%0b tail=%0b expected none",
                         out_flit, out_is_header, out_is_tail);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({out_flit, out_is_header, out_is_tail, out_port} !== mon_exp) begin
                    n_fail++;
                    $display("FAIL flit_out: got %h h=%0b t=%0b port=%0d expected %h h=%0b t=%0b port=%0d",
                             out_flit, out_is_header, out_is_tail, out_port,
                             mon_exp.flit, mon_exp.hdr, mon_exp.tail, mon_exp.port);
                end
            end
        end
    end

    initial begin
        // Reset state
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        check("rst_framing_err", 64'(framing_err), 64'd0);
        check("rst_out_port", 64'(out_port), 64'd0);
        check("rst_out_flit", out_flit, 64'd0);
        @(posedge noc_clk);
        #1;
        noc_rst_n = 1'b1;
        @(posedge noc_clk);
        #1;

        // 1: latency and a 3-flit EAST packet
        out_ready = 1'b0;
        send(hdr_flit(4'd3, 4'd1, 8'h10), 1'b1, 1'b0, 1'b1, 3'd1);
        check("t1_valid_at_t", 64'(out_valid), 64'd0);
        @(posedge noc_clk);
        #1;
        check("t1_valid_at_t1", 64'(out_valid), 64'd1);
        check("t1_port", 64'(out_port), 64'd1);
        out_ready = 1'b1;
        send(dat_flit(8'h11), 1'b0, 1'b0, 1'b1, 3'd1);
        send(dat_flit(8'h12), 1'b0, 1'b1, 1'b1, 3'd1);
        drain();
        check("t1_pkt_cnt", 64'(pkt_cnt), 64'd1);

        // 2: route decode for each direction
        send(hdr_flit(4'd1, 4'd1, 8'h20), 1'b1, 1'b1, 1'b1, 3'd0);
        send(hdr_flit(4'd0, 4'd1, 8'h21), 1'b1, 1'b1, 1'b1, 3'd2);
        send(hdr_flit(4'd1, 4'd3, 8'h22), 1'b1, 1'b1, 1'b1, 3'd3);
        send(hdr_flit(4'd1, 4'd0, 8'h23), 1'b1, 1'b1, 1'b1, 3'd4);
        send(hdr_flit(4'd2, 4'd0, 8'h24), 1'b1, 1'b1, 1'b1, 3'd1);
        drain();
        check("t2_pkt_cnt", 64'(pkt_cnt), 64'd6);

        // 3: full FIFO backpressure
        out_ready = 1'b0;
        send(hdr_flit(4'd2, 4'd1, 8'h30), 1'b1, 1'b0, 1'b1, 3'd1);
        send(dat_flit(8'h31), 1'b0, 1'b0, 1'b1, 3'd1);
        send(dat_flit(8'h32), 1'b0, 1'b0, 1'b1, 3'd1);
        send(dat_flit(8'h33), 1'b0, 1'b0, 1'b1, 3'd1);
        check("t3_full_not_ready", 64'(in_ready), 64'd0);
        fork
            send(dat_flit(8'h34), 1'b0, 1'b1, 1'b1, 3'd1);
            begin
                @(posedge noc_clk);
                #1;
                check("t3_still_full", 64'(in_ready), 64'd0);
                out_ready = 1'b1;
                @(posedge noc_clk);
                t_pop = $time;
                #1;
                check("t3_ready_after_pop", 64'(in_ready), 64'd1);
            end
        join
        check("t3_accept_delay", 64'(last_acc - t_pop), 64'd10);
        drain();
        check("t3_pkt_cnt", 64'(pkt_cnt), 64'd7);

        // 4: orphan data and duplicate header are dropped
        send(dat_flit(8'h40), 1'b0, 1'b0, 1'b0, 3'd0);
        check("t4_orphan_err", 64'(framing_err), 64'd1);
        @(posedge noc_clk);
        #1;
        check("t4_err_pulse_end", 64'(framing_err), 64'd0);
        send(hdr_flit(4'd0, 4'd1, 8'h41), 1'b1, 1'b0, 1'b1, 3'd2);
        check("t4_hdr_no_err", 64'(framing_err), 64'd0);
        send(hdr_flit(4'd3, 4'd3, 8'h42), 1'b1, 1'b0, 1'b0, 3'd0);
        check("t4_dup_hdr_err", 64'(framing_err), 64'd1);
        send(dat_flit(8'h43), 1'b0, 1'b0, 1'b1, 3'd2);
        send(dat_flit(8'h44), 1'b0, 1'b1, 1'b1, 3'd2);
        drain();
        check("t4_pkt_cnt", 64'(pkt_cnt), 64'd8);

        // 5: single-flit packet then 3-flit packet, one-cycle bubble
        pop_t.delete();
        send(hdr_flit(4'd1, 4'd1, 8'h50), 1'b1, 1'b1, 1'b1, 3'd0);
        send(hdr_flit(4'd1, 4'd3, 8'h51), 1'b1, 1'b0, 1'b1, 3'd3);
        send(dat_flit(8'h52), 1'b0, 1'b0, 1'b1, 3'd3);
        send(dat_flit(8'h53), 1'b0, 1'b1, 1'b1, 3'd3);
        drain();
        check("t5_pop_count", 64'(pop_t.size()), 64'd4);
        if (pop_t.size() == 4) begin
            check("t5_bubble", 64'(pop_t[1] - pop_t[0]), 64'd20);
            check("t5_stream", 64'(pop_t[3] - pop_t[1]), 64'd20);
        end
        check("t5_pkt_cnt", 64'(pkt_cnt), 64'd10);

        // 6: reset mid-packet
        out_ready = 1'b0;
        send(hdr_flit(4'd3, 4'd0, 8'h60), 1'b1, 1'b0, 1'b1, 3'd1);
        send(dat_flit(8'h61), 1'b0, 1'b0, 1'b1, 3'd1);
        noc_rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 64'(out_valid), 64'd0);
        check("t6_rst_ready", 64'(in_ready), 64'd1);
        check("t6_rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        exp_q.delete();
        @(posedge noc_clk);
        #1;
        noc_rst_n = 1'b1;
        out_ready = 1'b1;
        send(hdr_flit(4'd0, 4'd1, 8'h62), 1'b1, 1'b0, 1'b1, 3'd2);
        send(dat_flit(8'h63), 1'b0, 1'b1, 1'b1, 3'd2);
        drain();
        check("t6_pkt_cnt", 64'(pkt_cnt), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/noc_flit_input_unit.md
Name: noc_flit_input_unit

Overview:
- Router input port that sits directly downstream of a node's flit sender interface: valid/ready, flit, is_header, is_tail.
- Buffers flits in a FIFO and enforces packet framing by dropping orphan flits.
- Decodes the destination from each header flit and computes the XY output port.
- Presents flits, plus a route held stable for the whole packet, to the router switch allocator.

Parameters:
- DATA_W, 64, flit width.
- DEPTH, 4, FIFO entries; power of 2, ≥2.
- X_W, 4, X coordinate width.
- Y_W, 4, Y coordinate width.
- DST_LSB, 32, LSB of the destination field in a header flit. Dest Y = flit[DST_LSB +: Y_W]; dest X = flit[DST_LSB+Y_W +: X_W].
- MY_X, 0, this router's X coordinate.
- MY_Y, 0, this router's Y coordinate.

Ports:
- noc_clk  in  1  clock
- noc_rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream flit valid
- in_ready  out  1  unit can accept a flit
- in_flit  in  DATA_W  upstream flit
- in_is_header  in  1  flit is packet header
- in_is_tail  in  1  flit is packet tail
- out_valid  out  1  head-of-FIFO flit valid toward switch
- out_ready  in  1  switch accepts flit
- out_flit  out  DATA_W  head-of-FIFO flit
- out_is_header  out  1  head flit is header
- out_is_tail  out  1  head flit is tail
- out_port  out  3  route: 0 LOCAL, 1 EAST (+X), 2 WEST (−X), 3 NORTH (+Y), 4 SOUTH (−Y)
- framing_err  out  1  one-cycle pulse when a flit is dropped
- pkt_cnt  out  16  packets forwarded (tail pops); wraps at 65535→0

Behaviour:
- Reset (noc_rst_n asynchronous, active-low; clock noc_clk):
  - FIFO empty, count=0; write framer wr_in_pkt=0; read FSM R_IDLE.
  - out_valid=0, out_port=0, framing_err=0, pkt_cnt=0.
  - out_flit, out_is_header and out_is_tail driven 0 when FIFO empty.
  - in_ready=1.
  - Reset mid-packet discards all buffered flits and the partial route.
- in_ready = (count != DEPTH), decoded from the registered count. A pop in the same cycle does not make a full FIFO ready (no write-through).
- Accept = in_valid & in_ready. On accept, the write framer decides:
  - !wr_in_pkt & in_is_header: write. wr_in_pkt <= !in_is_tail (a header+tail single-flit packet is legal).
  - wr_in_pkt & !in_is_header: write. Clear wr_in_pkt if in_is_tail.
  - !wr_in_pkt & !in_is_header: drop (accepted, not written); framing_err=1 next cycle.
  - wr_in_pkt & in_is_header: drop; framing_err=1; wr_in_pkt unchanged.
- FIFO:
  - Circular buffer; pointers log2(DEPTH) bits, wrapping naturally; count log2(DEPTH)+1 bits.
  - Simultaneous push and pop leaves count unchanged.
  - Each entry stores {is_header, is_tail, flit}; the head entry drives out_* combinationally.
- Read FSM:
  - R_IDLE: out_valid=0. If count≠0 and the head is a header, register out_port from the head's dest field and go to R_ACTIVE. A non-header head cannot occur because the framer guarantees it.
  - R_ACTIVE: out_valid = (count≠0). Pop on out_valid & out_ready. Popping a tail returns to R_IDLE and increments pkt_cnt.
  - out_port holds from the header through the tail pop.
- Route computation (XY, X first):
  - DX>MY_X → EAST; DX<MY_X → WEST.
  - Otherwise DY>MY_Y → NORTH, DY<MY_Y → SOUTH, else LOCAL.
  - Comparisons are unsigned.
- Latency:
  - Header accepted at edge t → count≠0 from t; route registered at t+1; out_valid=1 in the cycle after t+1. Minimum 2 cycles in-to-out.
  - Body flits stream at 1 flit/cycle when out_ready is held high.
- After a tail pop, the next packet's header is routed 1 cycle later (R_IDLE bubble).
- out_valid/out_flit stay stable while out_valid & !out_ready.

Test Plan:
1. MY=(1,1), send header (DX=3,DY=1), data, tail with out_ready=1 → out_valid rises 2 cycles after the header is accepted; 3 flits out in order; out_port=1 (EAST) for all 3; pkt_cnt=1.
2. Dests (1,1), (0,1), (1,3), (1,0), (2,0) → out_port 0, 2, 3, 4, 1 respectively.
3. DEPTH=4, out_ready=0, push 5 flits → in_ready=0 after 4 accepts; 5th held. Release out_ready → the 5th is accepted the cycle after the first pop; order preserved.
4. Send data flit with no header → framing_err pulses 1 cycle; nothing output. Send header, then header → 2nd dropped with err; packet completes normally.
5. Single-flit packet (header+tail) then immediately a 3-flit packet → pkt_cnt=1 then 2; out_port updates only at each header; 1-cycle gap between packets.
6. Assert noc_rst_n=0 after 2 of 3 flits are buffered → out_valid=0, in_ready=1, pkt_cnt=0 immediately. A fresh packet after release routes correctly.
